// File: rtl/audio_sample_scheduler_pkg.sv
// Shared types and defaults for the PWM audio sample scheduler.
package audio_pkg;

    localparam int WORD_LENGTH_DEFAULT = 16;

    typedef logic [WORD_LENGTH_DEFAULT-1:0] sample_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_TICK,
        SHIFT
    } state_t;

endpackage

// File: rtl/audio_sample_scheduler_if.sv
// Sample-source and serializer signals of the audio sample scheduler.
interface audio_sample_scheduler_if #(
    parameter int WORD_LENGTH = audio_pkg::WORD_LENGTH_DEFAULT,
    parameter int FIFO_DEPTH  = 4
);
    localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;

    logic                   run_i;
    logic [WORD_LENGTH-1:0] sample_i;
    logic                   sample_valid_i;
    logic                   sample_ready_o;
    logic                   ser_enable_o;
    logic [WORD_LENGTH-1:0] ser_data_o;
    logic                   ser_done_i;
    logic                   busy_o;
    logic [LEVEL_W-1:0]     fifo_level_o;
    logic [7:0]             underrun_count_o;
    logic [7:0]             overrun_count_o;

    // slave: the scheduler itself; master: the surrounding system
    modport slave (
        input  run_i, sample_i, sample_valid_i, ser_done_i,
        output sample_ready_o, ser_enable_o, ser_data_o, busy_o,
               fifo_level_o, underrun_count_o, overrun_count_o
    );

    modport master (
        output run_i, sample_i, sample_valid_i, ser_done_i,
        input  sample_ready_o, ser_enable_o, ser_data_o, busy_o,
               fifo_level_o, underrun_count_o, overrun_count_o
    );

endinterface

// File: rtl/audio_sample_scheduler_tick_gen.sv
// Sample-rate divider: one-cycle tick every TICK_DIV enabled cycles.
module audio_tick_gen #(
    parameter int TICK_DIV = 100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic tick
);
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (!enable) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = enable && (count == LAST);

endmodule

// File: rtl/audio_sample_scheduler.sv
// Buffers audio samples and hands one word per sample tick to the PWM serializer,
// holding the last word on underrun and skipping ticks that land mid-word.
module audio_sample_scheduler
    import audio_pkg::*;
#(
    parameter int                     WORD_LENGTH        = WORD_LENGTH_DEFAULT,
    parameter int                     SYSTEM_FREQUENCY   = 100000000,
    parameter int                     SAMPLING_FREQUENCY = 1000000,
    parameter int                     FIFO_DEPTH         = 4,
    parameter logic [WORD_LENGTH-1:0] IDLE_SAMPLE        = 16'h8000
) (
    input  logic                    clock_i,
    input  logic                    reset_n_i,
    audio_sample_scheduler_if.slave bus
);
    localparam int TICK_DIV = SYSTEM_FREQUENCY / SAMPLING_FREQUENCY;
    localparam int PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LEVEL_W  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [LEVEL_W-1:0] FULL_LEVEL = LEVEL_W'(FIFO_DEPTH);

    if (TICK_DIV < WORD_LENGTH + 4) begin : g_tick_div_check
        $error("TICK_DIV too small to fit one serializer word");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
        $error("FIFO_DEPTH must be a power of two and at least 2");
    end

    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

    state_t                 state;
    state_t                 state_next;
    logic                   tick;
    logic                   load;
    logic                   push;
    logic                   pop;
    logic                   full;
    logic                   empty;
    logic [WORD_LENGTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [LEVEL_W-1:0]     level;
    logic [WORD_LENGTH-1:0] ser_data;
    logic [WORD_LENGTH-1:0] last_sample;
    logic                   ser_enable;
    logic [7:0]             underrun_count;
    logic [7:0]             overrun_count;

    audio_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk    (clock_i),
        .rst_n  (reset_n_i),
        .enable (bus.run_i),
        .tick   (tick)
    );

    // Full/empty come from the registered level, so a pop never frees room
    // for a push in the same cycle.
    assign full  = (level == FULL_LEVEL);
    assign empty = (level == '0);
    assign push  = bus.sample_valid_i && !full;
    assign pop   = load && !empty;

    always_comb begin
        state_next = state;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.run_i) state_next = WAIT_TICK;
            end
            WAIT_TICK: begin
                if (!bus.run_i) begin
                    state_next = IDLE;
                end else if (tick) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.ser_done_i) state_next = bus.run_i ? WAIT_TICK : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state      <= IDLE;
            ser_enable <= 1'b0;
        end else begin
            state      <= state_next;
            ser_enable <= (state_next == SHIFT);
        end
    end

    always_ff @(posedge clock_i) begin
        if (push) mem[wr_ptr] <= bus.sample_i;
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Underrun replays the previous word so the PWM output holds its level.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ser_data    <= '0;
            last_sample <= IDLE_SAMPLE;
        end else if (load) begin
            ser_data <= pop ? mem[rd_ptr] : last_sample;
            if (pop) last_sample <= mem[rd_ptr];
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            underrun_count <= '0;
            overrun_count  <= '0;
        end else begin
            if (load && empty)              underrun_count <= sat_inc(underrun_count);
            if ((state == SHIFT) && tick)   overrun_count  <= sat_inc(overrun_count);
        end
    end

    assign bus.sample_ready_o   = !full;
    assign bus.ser_enable_o     = ser_enable;
    assign bus.busy_o           = ser_enable;
    assign bus.ser_data_o       = ser_data;
    assign bus.fifo_level_o     = level;
    assign bus.underrun_count_o = underrun_count;
    assign bus.overrun_count_o  = overrun_count;

endmodule

// File: tb/tb_audio_sample_scheduler.sv
// Scenario bench for audio_sample_scheduler with a simple serializer model.
module tb_audio_sample_scheduler;
    import audio_pkg::*;

    logic    clk = 1'b0;
    logic    rst_n;
    int      checks = 0;
    int      errors = 0;
    int      cycle = 0;
    int      done_delay = 17;
    int      ser_cnt;
    sample_t exp_q[$];

    audio_sample_scheduler_if #(.WORD_LENGTH(16), .FIFO_DEPTH(4)) bus ();

    audio_sample_scheduler #(
        .WORD_LENGTH        (16),
        .SYSTEM_FREQUENCY   (100000000),
        .SAMPLING_FREQUENCY (1000000),
        .FIFO_DEPTH         (4),
        .IDLE_SAMPLE        (16'h8000)
    ) dut (
        .clock_i   (clk),
        .reset_n_i (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    // Serializer model: done pulse in the done_delay-th cycle of enable.
    initial begin
        bus.ser_done_i = 1'b0;
        ser_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            bus.ser_done_i = 1'b0;
            if (bus.ser_enable_o) begin
                ser_cnt++;
                if (ser_cnt == done_delay) begin
                    bus.ser_done_i = 1'b1;
                    ser_cnt = 0;
                end
            end else begin
                ser_cnt = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        bus.run_i = 1'b0;
        bus.sample_valid_i = 1'b0;
        bus.sample_i = '0;
        done_delay = 17;
        exp_q.delete();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #2;
    endtask

    task automatic push_sample(input sample_t v, input bit expect_out);
        bus.sample_i = v;
        bus.sample_valid_i = 1'b1;
        @(posedge clk);
        #2;
        bus.sample_valid_i = 1'b0;
        if (expect_out) exp_q.push_back(v);
    endtask

    // Waits for the next rising ser_enable_o, compares the word against the
    // scoreboard head and optionally follows the word to its end.
    task automatic expect_word(input string name, input bit to_end,
                               output int start, output int len, output int lvl);
        bit      found;
        bit      prev;
        bit      stable;
        sample_t want;
        found = 1'b0;
        prev = bus.ser_enable_o;
        start = -1;
        len = 0;
        lvl = -1;
        for (int i = 0; i < 400 && !found; i++) begin
            @(posedge clk);
            #2;
            if (bus.ser_enable_o && !prev) found = 1'b1;
            prev = bus.ser_enable_o;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL %s_start: ser_enable_o rise seen=0 required=1 within 400 cycles", name);
            return;
        end
        start = cycle;
        lvl = int'(bus.fifo_level_o);
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s_data: got word %h but none was expected", name, bus.ser_data_o);
            return;
        end
        want = exp_q.pop_front();
        if (bus.ser_data_o !== want) begin
            errors++;
            $display("FAIL %s_data: ser_data_o=%h required=%h", name, bus.ser_data_o, want);
        end
        if (to_end) begin
            stable = 1'b1;
            for (int i = 0; i < 400 && bus.ser_enable_o; i++) begin
                if (bus.ser_data_o !== want || bus.busy_o !== bus.ser_enable_o) stable = 1'b0;
                len++;
                @(posedge clk);
                #2;
            end
            checks++;
            if (!stable || bus.busy_o !== 1'b0 || bus.ser_enable_o !== 1'b0) begin
                errors++;
                $display("FAIL %s_hold: stable=%0b busy_end=%b enable_end=%b required 1/0/0",
                         name, stable, bus.busy_o, bus.ser_enable_o);
            end
        end
    endtask

    task automatic count_rises(input int ncyc, output int rises);
        bit prev;
        prev = bus.ser_enable_o;
        rises = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk);
            #2;
            if (bus.ser_enable_o && !prev) rises++;
            prev = bus.ser_enable_o;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.ser_enable_o !== 1'b0) begin errors++; $display("FAIL reset_enable: got %b required 0", bus.ser_enable_o); end
        checks++;
        if (bus.ser_data_o !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h required 0000", bus.ser_data_o); end
        checks++;
        if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", bus.busy_o); end
        checks++;
        if (bus.sample_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", bus.sample_ready_o); end
        checks++;
        if (bus.fifo_level_o !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d required 0", bus.fifo_level_o); end
        checks++;
        if (bus.underrun_count_o !== 8'd0 || bus.overrun_count_o !== 8'd0) begin
            errors++;
            $display("FAIL reset_counters: underrun=%0d overrun=%0d required 0/0",
                     bus.underrun_count_o, bus.overrun_count_o);
        end
    endtask

    task automatic test_basic_stream();
        int s0, l0, v0, s1, l1, v1;
        do_reset();
        push_sample(16'h1234, 1'b1);
        push_sample(16'hABCD, 1'b1);
        checks++;
        if (bus.fifo_level_o !== 3'd2) begin errors++; $display("FAIL basic_level_fill: got %0d required 2", bus.fifo_level_o); end
        bus.run_i = 1'b1;
        expect_word("basic_w0", 1'b1, s0, l0, v0);
        checks++;
        if (l0 != 17) begin errors++; $display("FAIL basic_w0_len: got %0d required 17", l0); end
        checks++;
        if (v0 != 1) begin errors++; $display("FAIL basic_w0_level: got %0d required 1", v0); end
        expect_word("basic_w1", 1'b1, s1, l1, v1);
        checks++;
        if (s1 - s0 != 100) begin errors++; $display("FAIL basic_spacing: got %0d required 100", s1 - s0); end
        checks++;
        if (v1 != 0) begin errors++; $display("FAIL basic_w1_level: got %0d required 0", v1); end
        checks++;
        if (bus.underrun_count_o !== 8'd0) begin errors++; $display("FAIL basic_underrun: got %0d required 0", bus.underrun_count_o); end
        bus.run_i = 1'b0;
    endtask

    task automatic test_underrun();
        int s, l, v;
        do_reset();
        bus.run_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(16'h8000);
            expect_word("underrun_mid", 1'b1, s, l, v);
            checks++;
            if (bus.underrun_count_o !== 8'(i + 1)) begin
                errors++;
                $display("FAIL underrun_count_%0d: got %0d required %0d", i, bus.underrun_count_o, i + 1);
            end
        end
        push_sample(16'h00FF, 1'b1);
        exp_q.push_back(16'h00FF);
        expect_word("underrun_new", 1'b1, s, l, v);
        checks++;
        if (bus.underrun_count_o !== 8'd3) begin errors++; $display("FAIL underrun_after_push: got %0d required 3", bus.underrun_count_o); end
        expect_word("underrun_hold", 1'b1, s, l, v);
        checks++;
        if (bus.underrun_count_o !== 8'd4) begin errors++; $display("FAIL underrun_final: got %0d required 4", bus.underrun_count_o); end
        bus.run_i = 1'b0;
    endtask

    task automatic test_fifo_full();
        sample_t vals[5];
        int      s, l, v, rises;
        vals = '{16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.sample_ready_o !== (i < 4)) begin
                errors++;
                $display("FAIL full_ready_%0d: got %b required %b", i, bus.sample_ready_o, (i < 4));
            end
            bus.sample_i = vals[i];
            bus.sample_valid_i = 1'b1;
            @(posedge clk);
            #2;
            checks++;
            if (bus.fifo_level_o !== 3'((i < 4) ? i + 1 : 4)) begin
                errors++;
                $display("FAIL full_level_%0d: got %0d required %0d", i, bus.fifo_level_o, (i < 4) ? i + 1 : 4);
            end
        end
        bus.sample_valid_i = 1'b0;
        count_rises(150, rises);
        checks++;
        if (rises != 0) begin errors++; $display("FAIL full_no_enable: rises=%0d required 0", rises); end
        for (int i = 0; i < 4; i++) exp_q.push_back(vals[i]);
        exp_q.push_back(vals[3]);
        bus.run_i = 1'b1;
        for (int i = 0; i < 5; i++) expect_word("full_drain", 1'b1, s, l, v);
        checks++;
        if (bus.underrun_count_o !== 8'd1) begin errors++; $display("FAIL full_drain_underrun: got %0d required 1", bus.underrun_count_o); end
        bus.run_i = 1'b0;
    endtask

    task automatic test_overrun();
        int s0, l0, v0, s1, l1, v1;
        do_reset();
        push_sample(16'h1111, 1'b1);
        push_sample(16'h2222, 1'b1);
        push_sample(16'h3333, 1'b0);
        done_delay = 150;
        bus.run_i = 1'b1;
        expect_word("over_w0", 1'b1, s0, l0, v0);
        checks++;
        if (l0 != 150) begin errors++; $display("FAIL over_len: got %0d required 150", l0); end
        checks++;
        if (bus.overrun_count_o !== 8'd1) begin errors++; $display("FAIL over_count: got %0d required 1", bus.overrun_count_o); end
        checks++;
        if (bus.fifo_level_o !== 3'd2) begin errors++; $display("FAIL over_no_pop: level=%0d required 2", bus.fifo_level_o); end
        done_delay = 17;
        expect_word("over_w1", 1'b1, s1, l1, v1);
        checks++;
        if (s1 - s0 != 200) begin errors++; $display("FAIL over_gap: got %0d required 200", s1 - s0); end
        checks++;
        if (v1 != 1 || bus.underrun_count_o !== 8'd0) begin
            errors++;
            $display("FAIL over_w1_state: level=%0d underrun=%0d required 1/0", v1, bus.underrun_count_o);
        end
        bus.run_i = 1'b0;
    endtask

    task automatic test_stop_reset();
        int s, l, v, rises, len;
        do_reset();
        push_sample(16'hAAAA, 1'b1);
        push_sample(16'hBBBB, 1'b1);
        bus.run_i = 1'b1;
        expect_word("stop_w0", 1'b0, s, l, v);
        bus.run_i = 1'b0;
        len = 1;
        for (int i = 0; i < 400 && bus.ser_enable_o; i++) begin
            @(posedge clk);
            #2;
            if (bus.ser_enable_o) len++;
        end
        checks++;
        if (len != 17) begin errors++; $display("FAIL stop_complete_len: got %0d required 17", len); end
        count_rises(250, rises);
        checks++;
        if (rises != 0 || bus.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL stop_idle: rises=%0d busy=%b required 0/0", rises, bus.busy_o);
        end
        checks++;
        if (bus.fifo_level_o !== 3'd1) begin errors++; $display("FAIL stop_level: got %0d required 1", bus.fifo_level_o); end
        bus.run_i = 1'b1;
        expect_word("stop_w1", 1'b0, s, l, v);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.ser_enable_o !== 1'b0 || bus.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_async_enable: enable=%b busy=%b required 0/0", bus.ser_enable_o, bus.busy_o);
        end
        checks++;
        if (bus.fifo_level_o !== 3'd0 || bus.ser_data_o !== 16'h0000) begin
            errors++;
            $display("FAIL reset_async_state: level=%0d data=%h required 0/0000", bus.fifo_level_o, bus.ser_data_o);
        end
        bus.run_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        count_rises(150, rises);
        checks++;
        if (rises != 0) begin errors++; $display("FAIL reset_quiet: rises=%0d required 0", rises); end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.run_i = 1'b0;
        bus.sample_i = '0;
        bus.sample_valid_i = 1'b0;
        test_reset();
        test_basic_stream();
        test_underrun();
        test_fifo_full();
        test_overrun();
        test_stop_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
